// File: rtl/div_pkg.sv
// Shared constants and state encodings for the sequential restoring divider.
// Used by seq_divider32 and div_addsub_stage.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_LAT   = DIV_WIDTH + 3;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PREP = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      PREP = ST_PREP,
      RUN  = ST_RUN,
      FIX  = ST_FIX,
      DONE = ST_DONE
   } div_state_e;

endpackage

// File: rtl/div_addsub_stage.sv
// N-bit subtract stage (SUB=1 form of the ripple add/sub unit): diff = a - b, borrow on underflow.
// Serves both the per-cycle trial subtract and the 0 - x negations.
module div_addsub_stage
   import div_pkg::*;
#(
   parameter int N = DIV_WIDTH + 1
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider, one trial subtract per cycle, valid/ready on both sides.
// Optional SIGNED_DIV_EN macro adds two's-complement operation and the V (MIN / -1) flag.
module seq_divider32
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             div_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero,
   output logic             V
);

   localparam int CW = $clog2(WIDTH);

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_zero_q, div_zero_d;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH:0]   s0_a, s0_b, s0_diff;
   logic             s0_borrow;
   logic             unused_bits;

   div_addsub_stage #(.N(WIDTH + 1)) u_stage0 (
      .a      (s0_a),
      .b      (s0_b),
      .diff   (s0_diff),
      .borrow (s0_borrow)
   );

`ifdef SIGNED_DIV_EN
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             ovf_q, ovf_d;
   logic             v_q, v_d;
   logic [WIDTH:0]   s1_a, s1_b, s1_diff;
   logic             s1_borrow;

   // Second negator lets divisor/remainder be negated in the same cycle as dividend/quotient.
   div_addsub_stage #(.N(WIDTH + 1)) u_stage1 (
      .a      (s1_a),
      .b      (s1_b),
      .diff   (s1_diff),
      .borrow (s1_borrow)
   );

   assign V           = v_q;
   assign unused_bits = ^{rem_q[WIDTH], s1_diff[WIDTH], s1_borrow};
`else
   assign V           = 1'b0;
   assign unused_bits = ^{rem_q[WIDTH], div_signed};
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      rem_sh      = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      quo_sh      = {quo_q[WIDTH-2:0], 1'b0};
      s0_a        = rem_sh;
      s0_b        = {1'b0, dvs_q};
`ifdef SIGNED_DIV_EN
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      ovf_d       = ovf_q;
      v_d         = v_q;
      s1_a        = '0;
      s1_b        = {1'b0, dvs_q};
`endif

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               dvd_d      = dividend;
               dvs_d      = divisor;
               div_zero_d = 1'b0;
`ifdef SIGNED_DIV_EN
               v_d        = 1'b0;
               neg_rem_d  = div_signed & dividend[WIDTH-1];
               neg_quo_d  = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               ovf_d      = div_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                            && (divisor == {WIDTH{1'b1}});
`endif
               if (divisor == '0) begin
                  quotient_d  = {WIDTH{DIV_ZERO_QUO[0]}};
                  remainder_d = dividend;
                  div_zero_d  = 1'b1;
                  state_d     = DONE;
               end else begin
                  state_d = PREP;
               end
            end
         end

         PREP: begin
            rem_d   = '0;
            quo_d   = dvd_q;
            cnt_d   = CW'(WIDTH - 1);
            state_d = RUN;
`ifdef SIGNED_DIV_EN
            s0_a = '0;
            s0_b = {1'b0, dvd_q};
            if (neg_rem_q) begin
               quo_d = s0_diff[WIDTH-1:0];
            end
            // Divisor sign is recovered from the two captured sign flags.
            if (neg_quo_q ^ neg_rem_q) begin
               dvs_d = s1_diff[WIDTH-1:0];
            end
`endif
         end

         RUN: begin
            if (!s0_borrow) begin
               rem_d = s0_diff;
               quo_d = {quo_sh[WIDTH-1:1], 1'b1};
            end else begin
               rem_d = rem_sh;
               quo_d = quo_sh;
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = FIX;
            end
         end

         FIX: begin
            quotient_d  = quo_q;
            remainder_d = rem_q[WIDTH-1:0];
            state_d     = DONE;
`ifdef SIGNED_DIV_EN
            s0_a = '0;
            s0_b = {1'b0, quo_q};
            s1_b = rem_q;
            v_d  = ovf_q;
            if (neg_quo_q) begin
               quotient_d = s0_diff[WIDTH-1:0];
            end
            if (neg_rem_q) begin
               remainder_d = s1_diff[WIDTH-1:0];
            end
`endif
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         ovf_q       <= 1'b0;
         v_q         <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
`ifdef SIGNED_DIV_EN
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         ovf_q       <= ovf_d;
         v_q         <= v_d;
`endif
      end
   end

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed corner cases plus randomized operands
// compared against a plain-arithmetic reference model (signed cases only with SIGNED_DIV_EN).
module tb_seq_divider32;

   localparam int W   = 32;
   localparam int LAT = W + 3;

   logic         clk        = 1'b0;
   logic         rst_n      = 1'b0;
   logic         in_valid   = 1'b0;
   logic         out_ready  = 1'b0;
   logic         div_signed = 1'b0;
   logic [W-1:0] dividend   = '0;
   logic [W-1:0] divisor    = '0;
   logic         in_ready;
   logic         out_valid;
   logic         div_zero;
   logic         V;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;

   int checkCount = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   seq_divider32 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .div_signed (div_signed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_zero   (div_zero),
      .V          (V)
   );

   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: plain division semantics; SV signed / and % truncate toward zero like the spec.
   function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z, output logic v);
      z = 1'b0;
      v = 1'b0;
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end
`ifdef SIGNED_DIV_EN
      else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = '0;
         v = 1'b1;
      end else if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
`endif
      else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic checkResult(input string tag, input logic [W-1:0] expQ, input logic [W-1:0] expR,
                              input logic expZ, input logic expV);
      checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({tag, ".q"}, quotient, expQ);
      checkOutput({tag, ".r"}, remainder, expR);
      checkOutput({tag, ".div_zero"}, {31'b0, div_zero}, {31'b0, expZ});
      checkOutput({tag, ".V"}, {31'b0, V}, {31'b0, expV});
   endtask

   task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input int hold);
      logic [W-1:0] expQ, expR;
      logic         expZ, expV;
      int           n;
      refModel(a, b, s, expQ, expR, expZ, expV);
      @(negedge clk);
      checkOutput({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
      in_valid   = 1'b1;
      dividend   = a;
      divisor    = b;
      div_signed = s;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      dividend   = $urandom;
      divisor    = $urandom;
      div_signed = ~s;
      n = 1;
      while (!out_valid && n < 4 * LAT) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({tag, ".latency"}, 32'(n), 32'(expZ ? 1 : LAT));
      checkResult(tag, expQ, expR, expZ, expV);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         checkResult({tag, ".hold"}, expQ, expR, expZ, expV);
         checkOutput({tag, ".hold.in_ready"}, {31'b0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, ".drain.valid"}, {31'b0, out_valid}, 32'd0);
      checkOutput({tag, ".drain.in_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
      checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
      checkOutput({tag, ".q"}, quotient, 32'd0);
      checkOutput({tag, ".r"}, remainder, 32'd0);
      checkOutput({tag, ".div_zero"}, {31'b0, div_zero}, 32'd0);
      checkOutput({tag, ".V"}, {31'b0, V}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] a, b;
      int           pick;

      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("u100div7", 32'd100, 32'd7, 1'b0, 0);
      applyStimulus("umaxdiv1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
      applyStimulus("u5div9", 32'd5, 32'd9, 1'b0, 0);
      applyStimulus("divzero", 32'h1234_5678, 32'd0, 1'b0, 0);
      applyStimulus("backpressure", 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 10);
`ifdef SIGNED_DIV_EN
      applyStimulus("sneg7div2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
      applyStimulus("sminovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2);
      applyStimulus("s7divneg2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
      applyStimulus("sdivzero", 32'h8000_0000, 32'd0, 1'b1, 0);
`endif

      for (int i = 0; i < 24; i++) begin
         pick = $urandom_range(0, 7);
         a    = $urandom;
         if (pick == 7) a = 32'h8000_0000;
         if (pick == 0)      b = '0;
         else if (pick < 4)  b = 32'($urandom_range(1, 15));
         else if (pick == 6) b = 32'hFFFF_FFFF;
         else                b = $urandom;
         applyStimulus($sformatf("rnd%0d", i), a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end

      // Leave non-zero results in the output registers, then reset during an operation.
      applyStimulus("prereset", 32'd100, 32'd7, 1'b0, 0);
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 32'hCAFE_F00D;
      divisor  = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (13) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetState("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("postreset", 32'hCAFE_F00D, 32'd3, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
